hfm_sparse_expander: RTL and testbench

- Consumer of the HFM global-buffer output streams: data stream (GBB, packed non-zero bytes) and flag stream (GBFB, zero/non-zero bitmap).
- Re-expands packed bytes into dense 16-byte activation vectors for the SSCNN PE array.
- Sits directly downstream of the HFM GBB/GBFB read ports.
- One flag beat (128 bits) describes 8 dense vectors; the data stream supplies popcount-many bytes per vector.

---
 rtl/hfm_pkg.sv | 19 +
 rtl/hfm_expand16.sv | 28 ++
 rtl/hfm_sparse_expander.sv | 169 ++++++++++++++++
 tb/tb_hfm_sparse_expander.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hfm_pkg.sv
// Shared constants and types for the HFM sparse expander: geometry of the packed
// data stream, the flag bitmap and the expander FSM state encoding.
package hfm_pkg;

   localparam int BYTE_NUM     = 16;
   localparam int DATA_W       = 8 * BYTE_NUM;
   localparam int ID_W         = 4;
   localparam int VEC_PER_FLAG = DATA_W / BYTE_NUM;
   localparam int BUF_W        = 2 * DATA_W;
   localparam int CNT_W        = 6;

   typedef enum logic {
      RUN   = 1'b0,
      DRAIN = 1'b1
   } hfm_exp_state_e;

   typedef logic [7:0] byte_t;

endpackage

// File: rtl/hfm_expand16.sv
// Prefix-sum mux network: scatters the lowest popcount(i_flag) buffer bytes onto
// the flagged byte lanes of one dense vector; also reports how many were used.
module hfm_expand16 import hfm_pkg::*; (
   input  logic [BYTE_NUM-1:0] i_flag,
   input  logic [BUF_W-1:0]    i_buf,
   output logic [DATA_W-1:0]   o_vec,
   output logic [4:0]          o_need
);

   logic [4:0] w_pos;
   byte_t      w_byte;

   // NOTE: every variable written here gets a default first so no latch is inferred.
   always_comb begin
      w_pos  = '0;
      w_byte = '0;
      o_vec  = '0;
      for (int j = 0; j < BYTE_NUM; j++) begin
         if (i_flag[j]) begin
            w_byte          = i_buf[8*w_pos +: 8];
            o_vec[8*j +: 8] = w_byte;
            w_pos           = w_pos + 5'd1;
         end
      end
      o_need = w_pos;
   end

endmodule

// File: rtl/hfm_sparse_expander.sv
// Re-expands packed non-zero bytes (GBB) into dense 16-byte vectors using the GBFB bitmap.
// Optional SPARSE_STAT_EN adds per-tile non-zero byte statistics outputs.
module hfm_sparse_expander import hfm_pkg::*; (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              soft_clr,
   input  logic              in_data_valid,
   output logic              in_data_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_data_last,
   input  logic              in_flag_valid,
   output logic              in_flag_ready,
   input  logic [DATA_W-1:0] in_flag,
   input  logic              in_flag_last,
   input  logic [ID_W-1:0]   in_id,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_last,
   output logic [ID_W-1:0]   out_id,
`ifdef SPARSE_STAT_EN
   output logic [10:0]       stat_nz_cnt,
   output logic              stat_vld,
`endif
   output logic              err_underflow
);

   hfm_exp_state_e    r_state, w_state_nxt;
   logic [BUF_W-1:0]  r_buf;
   logic [CNT_W-1:0]  r_cnt;
   logic [DATA_W-1:0] r_flag;
   logic              r_flag_vld, r_flag_last, r_first_flag, r_data_done;
   logic [2:0]        r_vec_idx;
   logic [ID_W-1:0]   r_tile_id, r_out_id;
   logic              r_out_valid, r_out_last, r_err;
   logic [DATA_W-1:0] r_out_data;

   logic [DATA_W-1:0] w_vec;
   logic [4:0]        w_need;
   logic [CNT_W-1:0]  w_need_ext, w_base_cnt;
   logic              w_fire, w_under, w_tile_end, w_data_acc, w_flag_acc, w_data_end;
   logic [BUF_W-1:0]  w_shift_buf, w_app;

   hfm_expand16 u_expand (
      .i_flag (r_flag[BYTE_NUM*r_vec_idx +: BYTE_NUM]),
      .i_buf  (r_buf),
      .o_vec  (w_vec),
      .o_need (w_need)
   );

   assign in_data_ready = (r_state == DRAIN) || (r_cnt <= CNT_W'(BYTE_NUM) && !r_data_done);
   assign in_flag_ready = !r_flag_vld && (r_state == RUN);
   assign w_data_acc    = in_data_valid && in_data_ready;
   assign w_flag_acc    = in_flag_valid && in_flag_ready;
   assign w_data_end    = w_data_acc && in_data_last;

   assign w_need_ext = {1'b0, w_need};
   assign w_fire     = r_flag_vld && (r_cnt >= w_need_ext || r_data_done) && (!r_out_valid || out_ready);
   assign w_under    = w_fire && (r_cnt < w_need_ext);
   assign w_tile_end = w_fire && (r_vec_idx == 3'(VEC_PER_FLAG - 1)) && r_flag_last;

   // Consumption is applied first, then an incoming beat lands right after the survivors.
   assign w_base_cnt  = !w_fire ? r_cnt : (w_under ? '0 : r_cnt - w_need_ext);
   assign w_shift_buf = w_fire ? (r_buf >> (8 * w_need)) : r_buf;
   assign w_app       = {{(BUF_W-DATA_W){1'b0}}, in_data} << (8 * w_base_cnt);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN:     if (w_tile_end && !r_data_done && !w_data_end) w_state_nxt = DRAIN;
         DRAIN:   if (w_data_end) w_state_nxt = RUN;
         default: w_state_nxt = RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (!rst_n || soft_clr) begin
         r_state      <= RUN;
         // NOTE: the byte buffer is reset too; bytes at or above cnt must read as zero so
         // an underflowing vector outputs 0 for the missing bytes.
         r_buf        <= '0;
         r_cnt        <= '0;
         r_flag       <= '0;
         r_flag_vld   <= 1'b0;
         r_flag_last  <= 1'b0;
         r_first_flag <= 1'b1;
         r_data_done  <= 1'b0;
         r_vec_idx    <= '0;
         r_tile_id    <= '0;
         r_out_id     <= '0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_out_last   <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state <= w_state_nxt;

         // A tile end drops any residue, including a beat accepted in the same cycle.
         if (w_tile_end || w_under) begin
            r_buf <= '0;
            r_cnt <= '0;
         end else if (w_data_acc && r_state == RUN) begin
            r_buf <= w_shift_buf | w_app;
            r_cnt <= w_base_cnt + CNT_W'(BYTE_NUM);
         end else begin
            r_buf <= w_shift_buf;
            r_cnt <= w_base_cnt;
         end

         if (w_tile_end)
            r_data_done <= 1'b0;
         else if (w_data_end && r_state == RUN)
            r_data_done <= 1'b1;

         if (w_flag_acc) begin
            r_flag       <= in_flag;
            r_flag_vld   <= 1'b1;
            r_flag_last  <= in_flag_last;
            r_vec_idx    <= '0;
            r_first_flag <= 1'b0;
            if (r_first_flag) r_tile_id <= in_id;
         end else if (w_fire) begin
            r_vec_idx <= r_vec_idx + 3'd1;
            if (r_vec_idx == 3'(VEC_PER_FLAG - 1)) begin
               r_flag_vld <= 1'b0;
               if (r_flag_last) r_first_flag <= 1'b1;
            end
         end

         if (w_fire) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_vec;
            r_out_last  <= w_tile_end;
            r_out_id    <= r_tile_id;
         end else if (out_ready) begin
            r_out_valid <= 1'b0;
         end

         if (w_under) r_err <= 1'b1;
      end
   end

   assign out_valid     = r_out_valid;
   assign out_data      = r_out_data;
   assign out_last      = r_out_last;
   assign out_id        = r_out_id;
   assign err_underflow = r_err;

`ifdef SPARSE_STAT_EN
   logic [10:0] r_stat_cnt;
   logic        r_stat_clr;

   // The first vector after a tile end restarts the count instead of accumulating.
   always_ff @(posedge clk) begin
      if (!rst_n || soft_clr) begin
         r_stat_cnt <= '0;
         r_stat_clr <= 1'b0;
      end else if (w_fire) begin
         r_stat_cnt <= (r_stat_clr ? 11'd0 : r_stat_cnt) + 11'(w_need);
         r_stat_clr <= w_tile_end;
      end
   end

   assign stat_nz_cnt = r_stat_cnt;
   assign stat_vld    = r_out_valid && out_ready && r_out_last;
`endif

endmodule

// File: tb/tb_hfm_sparse_expander.sv
// Directed bench for hfm_sparse_expander: table of single-beat tiles plus hand-written
// sequences for full-density, back-pressure, drain and soft-clear corners.
module tb_hfm_sparse_expander;
   import hfm_pkg::*;

   logic              clk, rst_n, soft_clr;
   logic              in_data_valid, in_data_ready, in_data_last;
   logic [DATA_W-1:0] in_data;
   logic              in_flag_valid, in_flag_ready, in_flag_last;
   logic [DATA_W-1:0] in_flag;
   logic [ID_W-1:0]   in_id;
   logic              out_valid, out_ready, out_last, err_underflow;
   logic [DATA_W-1:0] out_data;
   logic [ID_W-1:0]   out_id;
`ifdef SPARSE_STAT_EN
   logic [10:0]       stat_nz_cnt;
   logic              stat_vld;
`endif

   hfm_sparse_expander dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .soft_clr      (soft_clr),
      .in_data_valid (in_data_valid),
      .in_data_ready (in_data_ready),
      .in_data       (in_data),
      .in_data_last  (in_data_last),
      .in_flag_valid (in_flag_valid),
      .in_flag_ready (in_flag_ready),
      .in_flag       (in_flag),
      .in_flag_last  (in_flag_last),
      .in_id         (in_id),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_last      (out_last),
      .out_id        (out_id),
`ifdef SPARSE_STAT_EN
      .stat_nz_cnt   (stat_nz_cnt),
      .stat_vld      (stat_vld),
`endif
      .err_underflow (err_underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              last;
      logic [ID_W-1:0]   id;
   } obs_t;
   obs_t obs_q[$];

   // Every accepted output vector is recorded in arrival order.
   always @(negedge clk) begin
      if (out_valid && out_ready) obs_q.push_back('{out_data, out_last, out_id});
   end

   task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_flag(input logic [DATA_W-1:0] f, input logic l, input logic [ID_W-1:0] id);
      int n = 0;
      @(negedge clk);
      in_flag = f; in_flag_last = l; in_id = id; in_flag_valid = 1'b1;
      while (!in_flag_ready && n < 1000) begin @(negedge clk); n++; end
      check("flag_accept_timeout", 136'(n < 1000), 136'(1));
      @(posedge clk); #1;
      in_flag_valid = 1'b0;
   endtask

   task automatic send_data(input logic [DATA_W-1:0] d, input logic l);
      int n = 0;
      @(negedge clk);
      in_data = d; in_data_last = l; in_data_valid = 1'b1;
      while (!in_data_ready && n < 1000) begin @(negedge clk); n++; end
      check("data_accept_timeout", 136'(n < 1000), 136'(1));
      @(posedge clk); #1;
      in_data_valid = 1'b0;
   endtask

   task automatic wait_vecs(input int n);
      int c = 0;
      while (obs_q.size() < n && c < 2000) begin @(negedge clk); c++; end
      check("vector_timeout", 136'(obs_q.size() >= n), 136'(1));
   endtask

   task automatic expect_vec(input string nm, input logic [DATA_W-1:0] d, input logic l,
                             input logic [ID_W-1:0] id);
      obs_t o;
      if (obs_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: no vector, expected %h", nm, d);
      end else begin
         o = obs_q.pop_front();
         check(nm, {o.id, o.last, o.data}, {id, l, d});
      end
   endtask

   typedef struct {
      logic [DATA_W-1:0] flag;
      logic [DATA_W-1:0] data;
      logic              has_data;
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] exp [8];
      logic              exp_err;
   } tile_t;
   tile_t tbl [4];

   logic [DATA_W-1:0] beats [8];
   logic [DATA_W-1:0] snap;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // One byte per vector; residual 8 bytes of the beat must be dropped.
      tbl[0].flag = {8{16'h0001}};
      tbl[0].data = 128'h1F1E1D1C_1B1A1918_17161514_13121110;
      tbl[0].has_data = 1'b1; tbl[0].id = 4'h3; tbl[0].exp_err = 1'b0;
      for (int v = 0; v < 8; v++) tbl[0].exp[v] = 128'(8'h10 + v);
      // All-zero bitmap, no data: eight zero vectors, then the tile drains.
      tbl[1].flag = '0; tbl[1].data = '0;
      tbl[1].has_data = 1'b0; tbl[1].id = 4'h5; tbl[1].exp_err = 1'b0;
      for (int v = 0; v < 8; v++) tbl[1].exp[v] = '0;
      // Mixed densities across slots.
      tbl[2].flag = {16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0110, 16'h0000, 16'h8000, 16'h0003};
      tbl[2].data = 128'hAFAEADAC_ABAAA9A8_A7A6A5A4_A3A2A1A0;
      tbl[2].has_data = 1'b1; tbl[2].id = 4'h9; tbl[2].exp_err = 1'b0;
      tbl[2].exp[0] = 128'hA1A0;
      tbl[2].exp[1] = {8'hA2, 120'h0};
      tbl[2].exp[2] = '0;
      tbl[2].exp[3] = 128'hA4_000000_A3_00000000;
      tbl[2].exp[4] = 128'hA5; tbl[2].exp[5] = 128'hA6;
      tbl[2].exp[6] = 128'hA7; tbl[2].exp[7] = 128'hA8;
      // Needs 20 bytes, only 16 supplied: second vector is short by 4.
      tbl[3].flag = {96'h0, 16'h00FF, 16'h0FFF};
      tbl[3].data = 128'h3F3E3D3C_3B3A3938_37363534_33323130;
      tbl[3].has_data = 1'b1; tbl[3].id = 4'hC; tbl[3].exp_err = 1'b1;
      tbl[3].exp[0] = 128'h3B3A3938_37363534_33323130;
      tbl[3].exp[1] = 128'h3F3E3D3C;
      for (int v = 2; v < 8; v++) tbl[3].exp[v] = '0;

      rst_n = 1'b0; soft_clr = 1'b0; out_ready = 1'b1;
      in_data_valid = 1'b0; in_data = '0; in_data_last = 1'b0;
      in_flag_valid = 1'b0; in_flag = '0; in_flag_last = 1'b0; in_id = '0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("rst_out", {out_valid, out_last, out_id, out_data}, '0);
      check("rst_err", 136'(err_underflow), 136'(0));
      check("rst_ready", {in_flag_ready, in_data_ready}, 136'(2'b11));

      // Full density: vectors equal the data beats.
      for (int k = 0; k < 8; k++)
         for (int i = 0; i < 16; i++) beats[k][8*i +: 8] = 8'(16*k + i + 1);
      fork
         send_flag({DATA_W{1'b1}}, 1'b1, 4'h1);
         for (int k = 0; k < 8; k++) send_data(beats[k], k == 7);
      join
      wait_vecs(8);
      for (int v = 0; v < 8; v++) expect_vec($sformatf("dense_v%0d", v), beats[v], v == 7, 4'h1);
`ifdef SPARSE_STAT_EN
      check("stat_nz_dense", 136'(stat_nz_cnt), 136'(128));
`endif

      for (int t = 0; t < 4; t++) begin
         fork
            send_flag(tbl[t].flag, 1'b1, tbl[t].id);
            if (tbl[t].has_data) send_data(tbl[t].data, 1'b1);
         join
         wait_vecs(8);
         for (int v = 0; v < 8; v++)
            expect_vec($sformatf("tbl%0d_v%0d", t, v), tbl[t].exp[v], v == 7, tbl[t].id);
         check($sformatf("tbl%0d_err", t), 136'(err_underflow), 136'(tbl[t].exp_err));
         if (!tbl[t].has_data) begin
            @(negedge clk);
            check($sformatf("tbl%0d_drain_flag_rdy", t), 136'(in_flag_ready), 136'(0));
            send_data('0, 1'b1);
         end
         check($sformatf("tbl%0d_flag_rdy", t), 136'(in_flag_ready), 136'(1));
      end

      // Back-pressure mid-tile: held vector must not change, order must survive.
      for (int k = 0; k < 8; k++)
         for (int i = 0; i < 16; i++) beats[k][8*i +: 8] = 8'(8'h80 + 16*k + i);
      fork
         send_flag({DATA_W{1'b1}}, 1'b1, 4'h7);
         for (int k = 0; k < 8; k++) send_data(beats[k], k == 7);
         begin
            int c = 0;
            while (obs_q.size() < 3 && c < 2000) begin @(negedge clk); c++; end
            @(posedge clk); #1 out_ready = 1'b0;
            repeat (3) @(negedge clk);
            check("stall_valid", 136'(out_valid), 136'(1));
            snap = out_data;
            for (int s = 0; s < 4; s++) begin
               @(negedge clk);
               check($sformatf("stall_hold%0d", s), {out_valid, out_data}, {1'b1, snap});
            end
            @(posedge clk); #1 out_ready = 1'b1;
         end
      join
      wait_vecs(8);
      for (int v = 0; v < 8; v++) expect_vec($sformatf("stall_v%0d", v), beats[v], v == 7, 4'h7);

      // Data outlives the flags: remaining beats are drained, flags blocked meanwhile.
      fork
         send_flag({112'h0, 16'h000F}, 1'b1, 4'hA);
         send_data(128'hF0E0D0C0_B0A09080_70605040_44332211, 1'b0);
      join
      wait_vecs(8);
      expect_vec("drain_v0", 128'h44332211, 1'b0, 4'hA);
      for (int v = 1; v < 8; v++) expect_vec($sformatf("drain_v%0d", v), '0, v == 7, 4'hA);
      @(negedge clk);
      check("drain_rdy0", {in_flag_ready, in_data_ready}, 136'(2'b01));
      send_data(128'h55, 1'b0);
      check("drain_rdy1", {in_flag_ready, in_data_ready}, 136'(2'b01));
      send_data(128'h66, 1'b1);
      check("drain_done_flag_rdy", 136'(in_flag_ready), 136'(1));

      // Soft clear with a vector held at the output (err is still set from the short tile).
      @(posedge clk); #1 out_ready = 1'b0;
      fork
         send_flag({DATA_W{1'b1}}, 1'b1, 4'h6);
         send_data(128'h1234, 1'b0);
      join
      begin
         int c = 0;
         while (!out_valid && c < 100) begin @(negedge clk); c++; end
      end
      check("clr_pre_valid", {out_valid, err_underflow}, 136'(2'b11));
      @(posedge clk); #1 soft_clr = 1'b1;
      @(posedge clk); #1 soft_clr = 1'b0;
      @(negedge clk);
      check("clr_out", {out_valid, out_last, out_id, out_data}, '0);
      check("clr_err", 136'(err_underflow), 136'(0));
      check("clr_ready", {in_flag_ready, in_data_ready}, 136'(2'b11));
      obs_q.delete();
      @(posedge clk); #1 out_ready = 1'b1;

      fork
         send_flag({112'h0, 16'h0001}, 1'b1, 4'h2);
         send_data(128'h77, 1'b1);
      join
      wait_vecs(8);
      expect_vec("post_clr_v0", 128'h77, 1'b0, 4'h2);
      for (int v = 1; v < 8; v++) expect_vec($sformatf("post_clr_v%0d", v), '0, v == 7, 4'h2);
      check("post_clr_err", 136'(err_underflow), 136'(0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
